pipe_ctrl: RTL

Central hazard and flush controller for the 5-stage pipeline: PC/IF, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Gathers hazard and event requests from the ID/EX/MEM/WB stages and both caches.
- Drives the per-stage stall and flush inputs of every stage register.
- Issues the single front-end PC redirect.
- Owns the idle-wait sequencing and the drain of the outstanding memory access before an exception redirect.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
//   ctrl_state_e : controller FSM encoding (RUN/DRAIN/IDLE)
//   STG_*        : bit positions of each stage in the stall/flush vectors
//   redir_cause_e: source selected for the front-end redirect
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } ctrl_state_e;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

  typedef enum logic [2:0] {
    RC_NONE   = 3'd0,
    RC_EXCEPT = 3'd1,
    RC_ERTN   = 3'd2,
    RC_SEQ    = 3'd3,
    RC_BRANCH = 3'd4
  } redir_cause_e;

  // WB redirect source: exception beats ertn, which beats refetch/idle (pc+4).
  function automatic redir_cause_e wb_cause(input logic except, input logic ertn);
    if (except)    return RC_EXCEPT;
    else if (ertn) return RC_ERTN;
    else           return RC_SEQ;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Central hazard and flush controller for the 5-stage pipeline.
// Inputs : WB event flags and PC, CSR eentry/era, interrupt pending,
//          EX branch resolution, load-use hazard, icache/dcache busy.
// Outputs: per-stage stall/flush, single PC redirect (valid + target),
//          FSM state for debug. Outputs are combinational from the
//          registered state and the current inputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned NSTAGE = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_pc,
  input  logic              wb_except,
  input  logic              wb_ertn,
  input  logic              wb_refetch,
  input  logic              wb_idle,
  input  logic [ADDR_W-1:0] eentry,
  input  logic [ADDR_W-1:0] era,
  input  logic              intr_pending,
  input  logic              ex_valid,
  input  logic              ex_br_mispredict,
  input  logic [ADDR_W-1:0] ex_br_target,
  input  logic              load_use,
  input  logic              icache_busy,
  input  logic              dcache_busy,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        ctrl_state
);

  ctrl_state_e  state, state_nxt;
  redir_cause_e cause;
  logic         rst_q;
  logic         wb_evt;

  assign wb_evt     = wb_valid && (wb_except || wb_ertn || wb_refetch || wb_idle);
  assign ctrl_state = state;

  // State register; rst_q stretches the reset output pattern one extra cycle.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next state and stall/flush/redirect-cause decode.
  always_comb begin
    state_nxt = state;
    stall     = '0;
    flush     = '0;
    cause     = RC_NONE;
    if (rst || rst_q) begin
      flush     = '1;
      state_nxt = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (wb_evt && dcache_busy) begin
            // Hold everything, including WB, until the MEM access retires.
            stall     = '1;
            state_nxt = ST_DRAIN;
          end else if (wb_evt) begin
            flush[STG_WB:STG_ID] = 4'b1111;
            cause                = wb_cause(wb_except, wb_ertn);
            if (wb_idle && !wb_except) state_nxt = ST_IDLE;
          end else if (ex_valid && ex_br_mispredict && !dcache_busy) begin
            flush[STG_EX:STG_ID] = 2'b11;
            cause                = RC_BRANCH;
          end else if (dcache_busy) begin
            stall[STG_MEM:STG_IF] = 4'b1111;
          end else if (load_use) begin
            stall[STG_ID:STG_IF] = 2'b11;
            flush[STG_EX]        = 1'b1;
          end else if (icache_busy) begin
            stall[STG_IF] = 1'b1;
            flush[STG_ID] = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (dcache_busy) begin
            stall = '1;
          end else begin
            // WB fields are still the held event; any mispredict dies in the flush.
            flush[STG_WB:STG_ID] = 4'b1111;
            cause                = wb_cause(wb_except, wb_ertn);
            state_nxt            = (wb_idle && !wb_except) ? ST_IDLE : ST_RUN;
          end
        end
        ST_IDLE: begin
          stall[STG_IF]        = 1'b1;
          flush[STG_WB:STG_ID] = 4'b1111;
          // PC already sits at idle+4, so wake without a redirect.
          if (intr_pending) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // Redirect target select.
  always_comb begin
    redirect_valid = (cause != RC_NONE);
    unique case (cause)
      RC_EXCEPT: redirect_pc = eentry;
      RC_ERTN:   redirect_pc = era;
      RC_SEQ:    redirect_pc = wb_pc + ADDR_W'(4);
      RC_BRANCH: redirect_pc = ex_br_target;
      default:   redirect_pc = '0;
    endcase
  end

endmodule
